// File: rtl/gf180mcu_fd_sc_mcu7t5v0__and4_dbnc.sv
// Debounced 4-input AND: Z follows A1&A2&A3&A4 once it has disagreed for THRESH enabled samples.
// Optional fall pulse ZF is compiled only under GF180MCU_FD_SC_MCU7T5V0__AND4_DBNC_FALL_PULSE_EN.
module gf180mcu_fd_sc_mcu7t5v0__and4_dbnc #(
  parameter int unsigned CNT_W  = 3,
  parameter int unsigned THRESH = 4
) (
  input  logic CLK,
  input  logic RST,
  input  logic EN,
  input  logic A1,
  input  logic A2,
  input  logic A3,
  input  logic A4,
  output logic Z,
  output logic ZR
`ifdef GF180MCU_FD_SC_MCU7T5V0__AND4_DBNC_FALL_PULSE_EN
  ,
  output logic ZF
`endif
);

  typedef enum logic [1:0] {
    IDLE_LO = 2'd0,
    PEND_HI = 2'd1,
    IDLE_HI = 2'd2,
    PEND_LO = 2'd3
  } state_e;

  localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(THRESH - 1);

  state_e           state_q;
  logic             m_q;
  logic [CNT_W-1:0] cnt_q;
  logic             z_q;
  logic             zr_q;
`ifdef GF180MCU_FD_SC_MCU7T5V0__AND4_DBNC_FALL_PULSE_EN
  logic             zf_q;
`endif

  logic mis_c;
  logic idle_c;
  logic toggle_c;

  // An unknown capture compares as "no mismatch" in simulation; hardware sees plain XOR.
  always_comb begin
    mis_c    = ((m_q ^ z_q) === 1'b1);
    idle_c   = (state_q == IDLE_LO) || (state_q == IDLE_HI);
    toggle_c = 1'b0;
    if (EN && mis_c) begin
      if (idle_c) toggle_c = (THRESH == 1);
      else        toggle_c = (cnt_q == CNT_LAST);
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= IDLE_LO;
      m_q     <= 1'b0;
      cnt_q   <= CNT_ZERO;
      z_q     <= 1'b0;
      zr_q    <= 1'b0;
`ifdef GF180MCU_FD_SC_MCU7T5V0__AND4_DBNC_FALL_PULSE_EN
      zf_q    <= 1'b0;
`endif
    end else begin
      m_q  <= A1 & A2 & A3 & A4;
      zr_q <= 1'b0;
`ifdef GF180MCU_FD_SC_MCU7T5V0__AND4_DBNC_FALL_PULSE_EN
      zf_q <= 1'b0;
`endif
      if (toggle_c) begin
        state_q <= z_q ? IDLE_LO : IDLE_HI;
        cnt_q   <= CNT_ZERO;
        z_q     <= ~z_q;
        zr_q    <= ~z_q;
`ifdef GF180MCU_FD_SC_MCU7T5V0__AND4_DBNC_FALL_PULSE_EN
        zf_q    <= z_q;
`endif
      end else if (EN) begin
        case (state_q)
          IDLE_LO, IDLE_HI: begin
            if (mis_c) begin
              state_q <= (state_q == IDLE_LO) ? PEND_HI : PEND_LO;
              cnt_q   <= CNT_ONE;
            end
          end
          PEND_HI, PEND_LO: begin
            if (!mis_c) begin
              state_q <= z_q ? IDLE_HI : IDLE_LO;
              cnt_q   <= CNT_ZERO;
            end else begin
              cnt_q <= cnt_q + CNT_ONE;
            end
          end
          default: begin
            state_q <= IDLE_LO;
            cnt_q   <= CNT_ZERO;
          end
        endcase
      end
    end
  end

  assign Z  = z_q;
  assign ZR = zr_q;
`ifdef GF180MCU_FD_SC_MCU7T5V0__AND4_DBNC_FALL_PULSE_EN
  assign ZF = zf_q;
`endif

endmodule

// File: tb/tb_gf180mcu_fd_sc_mcu7t5v0__and4_dbnc.sv
// Bench for the debounced AND4: THRESH=4 and THRESH=1 instances against a run-length model.
module tb_gf180mcu_fd_sc_mcu7t5v0__and4_dbnc;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en  = 1'b0;
  logic [3:0] a   = 4'h0;
  logic       z4, zr4, z1, zr1;
`ifdef GF180MCU_FD_SC_MCU7T5V0__AND4_DBNC_FALL_PULSE_EN
  logic       zf4, zf1;
`endif

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  gf180mcu_fd_sc_mcu7t5v0__and4_dbnc #(.CNT_W(3), .THRESH(4)) dut4 (
    .CLK(clk), .RST(rst), .EN(en),
    .A1(a[0]), .A2(a[1]), .A3(a[2]), .A4(a[3]),
    .Z(z4), .ZR(zr4)
`ifdef GF180MCU_FD_SC_MCU7T5V0__AND4_DBNC_FALL_PULSE_EN
    , .ZF(zf4)
`endif
  );

  gf180mcu_fd_sc_mcu7t5v0__and4_dbnc #(.CNT_W(3), .THRESH(1)) dut1 (
    .CLK(clk), .RST(rst), .EN(en),
    .A1(a[0]), .A2(a[1]), .A3(a[2]), .A4(a[3]),
    .Z(z1), .ZR(zr1)
`ifdef GF180MCU_FD_SC_MCU7T5V0__AND4_DBNC_FALL_PULSE_EN
    , .ZF(zf1)
`endif
  );

  // Model: Z flips once the sampled AND level has disagreed for th consecutive enabled edges.
  int th [2] = '{4, 1};
  int run[2];
  bit mz [2];
  bit mzr[2];
  bit mzf[2];
  bit mm;
  bit old_m;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mm = 1'b0;
      for (int i = 0; i < 2; i++) begin
        run[i] = 0; mz[i] = 1'b0; mzr[i] = 1'b0; mzf[i] = 1'b0;
      end
    end else begin
      old_m = mm;
      mm    = &a;
      for (int i = 0; i < 2; i++) begin
        mzr[i] = 1'b0;
        mzf[i] = 1'b0;
        if (en) begin
          if (old_m != mz[i]) begin
            run[i] = run[i] + 1;
            if (run[i] == th[i]) begin
              mz[i]  = ~mz[i];
              mzr[i] = mz[i];
              mzf[i] = ~mz[i];
              run[i] = 0;
            end
          end else begin
            run[i] = 0;
          end
        end
      end
    end
  end

  task automatic chk(input string name, input logic act, input logic exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    chk("z_t4",  z4,  mz[0]);
    chk("zr_t4", zr4, mzr[0]);
    chk("z_t1",  z1,  mz[1]);
    chk("zr_t1", zr1, mzr[1]);
`ifdef GF180MCU_FD_SC_MCU7T5V0__AND4_DBNC_FALL_PULSE_EN
    chk("zf_t4", zf4, mzf[0]);
    chk("zf_t1", zf1, mzf[1]);
`endif
  end

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_z_t4", z4, 1'b0);
    chk("rst_zr_t4", zr4, 1'b0);
    chk("rst_z_t1", z1, 1'b0);

    // Rise: all A high captured at e1 -> Z at e5 (THRESH=4) and e2 (THRESH=1).
    rst = 1'b0; en = 1'b1; a = 4'hF;
    for (int k = 1; k <= 6; k++) begin
      @(posedge clk); #1;
      chk("rise_z_t4",  z4,  k >= 5);
      chk("rise_zr_t4", zr4, k == 5);
      chk("rise_z_t1",  z1,  k >= 2);
      chk("rise_zr_t1", zr1, k == 2);
      chk("mdl_rise_z_t4", mz[0], k >= 5);
    end

    // Glitch: A3 low for two cycles is rejected by THRESH=4.
    @(negedge clk); a = 4'b1011;
    for (int k = 1; k <= 8; k++) begin
      @(posedge clk); #1;
      chk("glitch_z_t4",  z4,  1'b1);
      chk("glitch_zr_t4", zr4, 1'b0);
      @(negedge clk);
      if (k == 2) a = 4'hF;
    end

    // Freeze: EN low for three edges with cnt=2 in PEND_HI.
    a = 4'h0;
    repeat (8) @(negedge clk);
    chk("freeze_pre_z_t4", z4, 1'b0);
    a = 4'hF;
    for (int k = 1; k <= 10; k++) begin
      @(posedge clk); #1;
      chk("freeze_z_t4",  z4,  k >= 8);
      chk("freeze_zr_t4", zr4, k == 8);
      chk("mdl_freeze_z_t4", mz[0], k >= 8);
      @(negedge clk);
      if (k == 3) en = 1'b0;
      if (k == 6) en = 1'b1;
    end

    // Asynchronous reset while Z=1 clears Z before any clock edge.
    @(posedge clk); #2;
    chk("async_pre_z_t4", z4, 1'b1);
    rst = 1'b1; #1;
    chk("async_z_t4", z4, 1'b0);
    chk("async_z_t1", z1, 1'b0);
    @(negedge clk); rst = 1'b0; a = 4'h0;
    repeat (8) @(negedge clk);

    // Reset mid-PEND_HI with cnt=3: pending rise abandoned, no pulse on release.
    a = 4'hF;
    repeat (4) @(posedge clk);
    #2; rst = 1'b1; #1;
    chk("pend_rst_z_t4", z4, 1'b0);
    chk("pend_rst_zr_t4", zr4, 1'b0);
    @(negedge clk); rst = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      @(posedge clk); #1;
      chk("release_z_t4",  z4,  k >= 5);
      chk("release_zr_t4", zr4, k == 5);
    end

    // Randomized traffic with occasional asynchronous resets.
    begin
      bit lvl = 1'b1;
      for (int c = 0; c < 3000; c++) begin
        @(negedge clk);
        if ($urandom_range(0, 7) == 0) lvl = ~lvl;
        a = lvl ? 4'hF : 4'h0;
        if ($urandom_range(0, 5) == 0) a = 4'($urandom);
        en = ($urandom_range(0, 7) != 0);
        if ($urandom_range(0, 299) == 0) begin
          @(posedge clk); #2; rst = 1'b1;
          @(negedge clk); rst = 1'b0;
        end
      end
    end

    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/gf180mcu_fd_sc_mcu7t5v0__and4_dbnc.md
GF180MCU_FD_SC_MCU7T5V0__AND4_DBNC -- requirements
Module: gf180mcu_fd_sc_mcu7t5v0__and4_dbnc

Interface
REQ-001 SHALL have parameter CNT_W, default 3, giving the width of the consecutive-cycle counter.
REQ-002 SHALL have parameter THRESH, default 4, giving the number of consecutive disagreeing samples before Z changes; legal range 1..2^CNT_W-1.
REQ-003 SHALL have port CLK  input  1  sole clock; all flops rise-edge triggered.
REQ-004 SHALL have port RST  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port EN  input  1  count enable; low freezes the counter, state and Z.
REQ-006 SHALL have ports A1, A2, A3, A4  input  1 each  AND-match inputs.
REQ-007 SHALL have port Z  output  1  debounced level of A1&A2&A3&A4.
REQ-008 SHALL have port ZR  output  1  one-cycle pulse on each Z rise.
REQ-009 SHALL have port ZF  output  1  one-cycle pulse on each Z fall; present only with the macro in REQ-026.

Function
REQ-010 SHALL capture M_q <= A1&A2&A3&A4 on every CLK edge, independent of EN.
REQ-011 SHALL implement FSM states IDLE_LO, PEND_HI, IDLE_HI, PEND_LO; Z is 1 in IDLE_HI and PEND_LO, else 0.
REQ-012 SHALL, with EN=1 in IDLE_LO or IDLE_HI and M_q != Z, go to PEND_HI or PEND_LO respectively, with cnt=1.
REQ-013 SHALL, with EN=1 in PEND_x and M_q == Z, return to the matching IDLE state and clear cnt to 0 (glitch rejected, no pulse).
REQ-014 SHALL, with EN=1 in PEND_x, M_q != Z and cnt < THRESH-1, increment cnt.
REQ-015 SHALL, with EN=1 in PEND_x, M_q != Z and cnt == THRESH-1, toggle Z (enter the opposite IDLE state) and clear cnt.
REQ-016 SHALL, for THRESH=1, toggle Z directly from IDLE on the first EN=1 edge with M_q != Z, skipping PEND.
REQ-017 SHALL give latency: A stable from capture edge e1 with EN=1 throughout gives the Z change at edge e1+THRESH.
REQ-018 SHALL drive ZR high for exactly the one cycle following the edge at which Z goes 0->1, else 0; registered, no combinational path from inputs.
REQ-019 SHALL, with EN=0, hold state, cnt and Z, and drive ZR (and ZF) low on the next edge.
REQ-020 SHALL never wrap cnt; cnt never exceeds THRESH-1.
REQ-021 SHALL treat X on any A input as mismatch-neutral in simulation only; synthesis behaviour follows REQ-010.

Reset
REQ-022 SHALL, while RST=1, immediately force M_q=0, cnt=0, state=IDLE_LO, Z=0, ZR=0, ZF=0, regardless of CLK.
REQ-023 SHALL abandon a pending transition when RST asserts mid-PEND; no pulse is generated on release.
REQ-024 SHALL resume on the first CLK edge after RST deasserts, with M_q capturing on that edge.

Configuration
REQ-025 SHALL compile ZF only under macro GF180MCU_FD_SC_MCU7T5V0__AND4_DBNC_FALL_PULSE_EN.
REQ-026 SHALL, with the macro defined, drive ZF high for the one cycle following each Z 1->0 edge, reset 0; without it, omit port ZF and its flop entirely, with all other behaviour unchanged.

Verification
REQ-027 SHALL cover rise: THRESH=4, EN=1, all A=1 from e1 -> Z=1 at e5, ZR=1 for cycle e5..e6 only.
REQ-028 SHALL cover glitch: from IDLE_HI, A3=0 for 2 cycles then 1 -> Z stays 1, ZR/ZF stay 0, state returns to IDLE_HI.
REQ-029 SHALL cover freeze: EN=0 for 3 cycles after cnt=2 in PEND_HI -> cnt holds 2; EN=1 again -> Z=1 two edges later.
REQ-030 SHALL cover reset mid-PEND_HI (cnt=3): RST pulse -> Z=0, cnt=0 asynchronously; no ZR after release.
REQ-031 SHALL cover fall with macro defined: from Z=1, A1=0 held -> Z=0 at e1+4, ZF=1 one cycle; without the macro, ZF is absent and build is clean.
REQ-032 SHALL cover THRESH=1: all A=1 captured at e1 -> Z=1 at e2, ZR one cycle.
